// File: rtl/parking_sensor_gen.sv
// -----------------------------------------------------------------------------
// parking_sensor_gen
//
// Generates the two-sensor pattern that a car makes while passing through a
// parking-garage gate. There is an outer (entry-side) beam and an inner
// (exit-side) beam. Each request steps through three phases of equal length:
//   enter : 10 -> 11 -> 01   ({in_sig,out_sig})
//   exit  : 01 -> 11 -> 10
// A normal sequence ends with a done pulse and bumps the matching event counter.
// An abort ends it early with an aborted pulse and leaves both counters alone.
//
// Parameters
//   DWELL_W   width of the per-phase dwell count
//   CNT_W     width of the enter / exit event counters
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request one sequence (only sampled while idle)
//   dir        in   0 = enter, 1 = exit (latched with start)
//   dwell      in   cycles per phase, 0 treated as 1 (latched with start)
//   abort      in   cancel the running sequence (ignored while idle)
//   in_sig     out  registered outer-sensor drive
//   out_sig    out  registered inner-sensor drive
//   busy       out  high while a phase is being driven
//   done       out  one-cycle pulse on normal completion
//   aborted    out  one-cycle pulse on cancellation
//   enter_cnt  out  completed enter sequences (wraps)
//   exit_cnt   out  completed exit sequences (wraps)
// -----------------------------------------------------------------------------
module parking_sensor_gen #(
    parameter int DWELL_W = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               abort,
    output logic               in_sig,
    output logic               out_sig,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [CNT_W-1:0]   enter_cnt,
    output logic [CNT_W-1:0]   exit_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2,
        PH3  = 2'd3
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // A zero dwell would leave a phase with no cycles at all, so it is
    // floored to one cycle.
    function automatic logic [DWELL_W-1:0] dwell_floor(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_ONE : d;
    endfunction

    // Sensor drive for a given state and direction. The middle phase is 11 for
    // both directions, so consecutive phases only ever flip a single beam and
    // the pattern can never jump directly between 10 and 01.
    function automatic logic [1:0] phase_drive(input state_t s, input logic d);
        logic [1:0] drv;
        drv = 2'b00;
        case (s)
            PH1:     drv = d ? 2'b01 : 2'b10;
            PH2:     drv = 2'b11;
            PH3:     drv = d ? 2'b10 : 2'b01;
            default: drv = 2'b00;
        endcase
        return drv;
    endfunction

    state_t             state;
    state_t             state_nxt;
    logic [DWELL_W-1:0] tmr;
    logic [DWELL_W-1:0] tmr_nxt;
    logic [DWELL_W-1:0] dwell_q;
    logic               dir_q;

    logic               accept;
    logic               phase_end;
    logic               dir_nxt;
    logic [1:0]         drive_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               aborted_nxt;

    // A new request is only taken while idle; abort has no meaning there, so
    // start wins when both arrive together.
    assign accept = (state == IDLE) && start;

    // The down-counter is loaded with dwell_eff-1 on phase entry, so a phase
    // spends exactly dwell_eff cycles before the counter reads zero and the
    // FSM moves on.
    assign phase_end = (state != IDLE) && (tmr == '0);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    // Request parameters are captured only on acceptance, which makes dir and
    // dwell changes during a sequence invisible to it.
    always_ff @(posedge clk) begin
        if (accept) begin
            dir_q   <= dir;
            dwell_q <= dwell_floor(dwell);
        end
    end

    // ---------------------------------------------------------------- next-state logic
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PH1;
                    tmr_nxt   = dwell_floor(dwell) - DWELL_ONE;
                end
            end
            PH1, PH2, PH3: begin
                if (abort) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end else if (phase_end) begin
                    case (state)
                        PH1:     state_nxt = PH2;
                        PH2:     state_nxt = PH3;
                        default: state_nxt = IDLE;
                    endcase
                    tmr_nxt = (state == PH3) ? '0 : (dwell_q - DWELL_ONE);
                end else begin
                    tmr_nxt = tmr - DWELL_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                tmr_nxt   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------- output logic
    // Outputs are computed from the upcoming state and then registered, so the
    // drive seen in a cycle always matches the state held in that cycle.
    always_comb begin
        dir_nxt     = accept ? dir : dir_q;
        drive_nxt   = phase_drive(state_nxt, dir_nxt);
        busy_nxt    = (state_nxt != IDLE);
        // Abort on the final PH3 cycle takes priority over completion.
        done_nxt    = (state == PH3) && phase_end && !abort;
        aborted_nxt = (state != IDLE) && abort;
    end

    // ---------------------------------------------------------------- output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            in_sig    <= 1'b0;
            out_sig   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            enter_cnt <= '0;
            exit_cnt  <= '0;
        end else begin
            in_sig  <= drive_nxt[1];
            out_sig <= drive_nxt[0];
            busy    <= busy_nxt;
            done    <= done_nxt;
            aborted <= aborted_nxt;
            // Counters move on the same edge that raises done and simply wrap.
            if (done_nxt && !dir_q) begin
                enter_cnt <= enter_cnt + CNT_ONE;
            end
            if (done_nxt && dir_q) begin
                exit_cnt <= exit_cnt + CNT_ONE;
            end
        end
    end

endmodule
